// File: rtl/regfile_wr_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot write-enable decoder for the register
// file, with a sequenced sweep mode that walks every output for clear passes.
// Ports:
//   Clock, Reset   rising-edge clock, async active-high reset
//   EN, Sel        decode enable and select (decode mode)
//   Mode, Start    Mode=1 with Start launches a sweep from IDLE/DONE
//   Abort          terminates a sweep in progress
//   Y              registered one-hot / all-zero enables
//   Idx            index of the asserted sweep output
//   Busy, Done     sweep in progress / one-cycle completion pulse
module regfile_wr_decoder #(
  parameter int SEL_W      = 3,
  parameter int SWEEP_HOLD = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  EN,
  input  logic [SEL_W-1:0]      Sel,
  input  logic                  Mode,
  input  logic                  Start,
  input  logic                  Abort,
  output logic [2**SEL_W-1:0]   Y,
  output logic [SEL_W-1:0]      Idx,
  output logic                  Busy,
  output logic                  Done
);

  localparam int OUT_N = 2**SEL_W;
  localparam int HW    = $clog2(SWEEP_HOLD) + 1;

  localparam logic [OUT_N-1:0] ONE      = OUT_N'(1);
  localparam logic [HW-1:0]    HOLD_END = HW'(SWEEP_HOLD - 1);
  localparam logic [SEL_W-1:0] IDX_END  = SEL_W'(OUT_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [OUT_N-1:0] y_q;
  logic [SEL_W-1:0] idx_q;
  logic [HW-1:0]    hold_q;
  logic             busy_q;
  logic             done_q;

  logic start_sweep;
  assign start_sweep = Start & Mode;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        SWEEP: begin
          if (Abort) begin
            // Abort beats the final-hold edge: no Done pulse.
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (hold_q == HOLD_END) begin
            hold_q <= '0;
            if (idx_q == IDX_END) begin
              state_q <= DONE;
              y_q     <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + SEL_W'(1);
              y_q   <= y_q << 1;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          // IDLE and DONE both decode; DONE lasts one cycle.
          hold_q <= '0;
          idx_q  <= '0;
          done_q <= 1'b0;
          if (start_sweep) begin
            state_q <= SWEEP;
            y_q     <= ONE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            y_q     <= EN ? (ONE << Sel) : '0;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign Idx  = idx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Directed-vector bench for regfile_wr_decoder (SEL_W=3, SWEEP_HOLD=2).
// Each task drives one scenario and checks outputs one cycle after edges.
module tb_regfile_wr_decoder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       EN;
  logic [2:0] Sel;
  logic       Mode;
  logic       Start;
  logic       Abort;
  logic [7:0] Y;
  logic [2:0] Idx;
  logic       Busy;
  logic       Done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                         8'h10, 8'h20, 8'h40, 8'h80};

  regfile_wr_decoder #(.SEL_W(3), .SWEEP_HOLD(2)) dut (
    .Clock(Clock), .Reset(Reset), .EN(EN), .Sel(Sel),
    .Mode(Mode), .Start(Start), .Abort(Abort),
    .Y(Y), .Idx(Idx), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({Y, Idx, Busy, Done} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset: Y=%h Idx=%0d Busy=%b Done=%b, want all 0",
               Y, Idx, Busy, Done);
    end
  endtask

  task automatic test_decode_basic();
    EN = 1; Sel = 3'd5;
    tick();
    vectors++;
    if (Y !== 8'h20) begin
      miscompares++;
      $display("FAIL decode_sel5: Y=%h want 20", Y);
    end
    EN = 0;
    tick();
    vectors++;
    if (Y !== 8'h00) begin
      miscompares++;
      $display("FAIL decode_en0: Y=%h want 00", Y);
    end
  endtask

  task automatic test_decode_walk();
    EN = 1;
    for (int s = 0; s < 8; s++) begin
      Sel = 3'(s);
      tick();
      vectors++;
      if (Y !== oh[s] || Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL decode_walk[%0d]: Y=%h Busy=%b want %h/0",
                 s, Y, Busy, oh[s]);
      end
    end
    EN = 0;
    tick();
  endtask

  task automatic test_abort_idle();
    EN = 1; Sel = 3'd1; Abort = 1;
    tick();
    vectors++;
    if (Y !== 8'h02 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: Y=%h Busy=%b want 02/0", Y, Busy);
    end
    Abort = 0; EN = 0;
    tick();
  endtask

  task automatic test_sweep(input bit poke_start);
    EN = 1; Sel = 3'd6; Mode = 1; Start = 1;
    tick();
    Start = 0; Mode = 0;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (Y !== oh[i/2] || Idx !== 3'(i/2) || Busy !== 1'b1 ||
          Done !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep[%0d]: Y=%h Idx=%0d Busy=%b Done=%b want %h/%0d/1/0",
                 i, Y, Idx, Busy, Done, oh[i/2], i/2);
      end
      if (poke_start && i == 5) begin
        Start = 1; Mode = 1;
      end else begin
        Start = 0; Mode = 0;
      end
      tick();
    end
    EN = 0;
    vectors++;
    if (Y !== 8'h00 || Busy !== 1'b0 || Done !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_done: Y=%h Busy=%b Done=%b want 00/0/1",
               Y, Busy, Done);
    end
    tick();
    vectors++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Y !== 8'h00) begin
      miscompares++;
      $display("FAIL sweep_after: Y=%h Busy=%b Done=%b want 00/0/0",
               Y, Busy, Done);
    end
  endtask

  task automatic test_abort();
    Mode = 1; Start = 1;
    tick();
    Start = 0; Mode = 0;
    repeat (6) tick();
    vectors++;
    if (Idx !== 3'd3 || Y !== 8'h08) begin
      miscompares++;
      $display("FAIL abort_pre: Idx=%0d Y=%h want 3/08", Idx, Y);
    end
    Abort = 1;
    tick();
    Abort = 0;
    vectors++;
    if (Y !== 8'h00 || Busy !== 1'b0 || Idx !== 3'd0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: Y=%h Busy=%b Idx=%0d Done=%b want 00/0/0/0",
               Y, Busy, Idx, Done);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_post[%0d]: Done=%b Busy=%b want 0/0",
                 i, Done, Busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    Mode = 1; Start = 1;
    tick();
    Start = 0; Mode = 0;
    repeat (15) tick();
    Mode = 1; Start = 1;
    tick();
    vectors++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done: Done=%b Busy=%b want 1/0", Done, Busy);
    end
    tick();
    Start = 0; Mode = 0;
    vectors++;
    if (Busy !== 1'b1 || Y !== 8'h01 || Idx !== 3'd0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_restart: Busy=%b Y=%h Idx=%0d Done=%b want 1/01/0/0",
               Busy, Y, Idx, Done);
    end
    Abort = 1;
    tick();
    Abort = 0;
    tick();
  endtask

  task automatic test_async_reset();
    Mode = 1; Start = 1;
    tick();
    Start = 0; Mode = 0;
    repeat (3) tick();
    #2;
    Reset = 1;
    #1;
    vectors++;
    if ({Y, Idx, Busy, Done} !== 13'h0) begin
      miscompares++;
      $display("FAIL async_reset: Y=%h Idx=%0d Busy=%b Done=%b want all 0",
               Y, Idx, Busy, Done);
    end
    #2;
    Reset = 0;
    EN = 1; Sel = 3'd2;
    tick();
    vectors++;
    if (Y !== 8'h04 || Busy !== 1'b0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: Y=%h Busy=%b Done=%b want 04/0/0",
               Y, Busy, Done);
    end
    EN = 0;
    tick();
  endtask

  task automatic test_start_mode0();
    Start = 1; Mode = 0; EN = 1; Sel = 3'd7;
    tick();
    vectors++;
    if (Busy !== 1'b0 || Y !== 8'h80) begin
      miscompares++;
      $display("FAIL start_mode0: Busy=%b Y=%h want 0/80", Busy, Y);
    end
    tick();
    vectors++;
    if (Busy !== 1'b0 || Y !== 8'h80) begin
      miscompares++;
      $display("FAIL start_mode0_hold: Busy=%b Y=%h want 0/80", Busy, Y);
    end
    Start = 0; EN = 0;
    tick();
  endtask

  initial begin
    Reset = 1; EN = 0; Sel = '0; Mode = 0; Start = 0; Abort = 0;
    #1;
    test_reset();
    #11;
    Reset = 0;
    test_decode_basic();
    test_decode_walk();
    test_abort_idle();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_start_mode0();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
